// File: rtl/npu_cube_add_pkg.sv
`default_nettype none
// ============================================================================
// Module  : npu_cube_add_pkg
// Purpose : Shared types and width helpers for the cube add carry-save
//           accumulator (FSM state encoding, accumulator/counter widths).
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package npu_cube_add_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACC     = 2'd1,
      RESOLVE = 2'd2,
      HOLD    = 2'd3
   } state_t;

   // Accumulator width: enough headroom for MAX_LEN full-scale operands.
   function automatic int acc_width(input int data_w, input int max_len);
      return data_w + $clog2(max_len);
   endfunction

   // Counter width: must be able to hold MAX_LEN itself.
   function automatic int cnt_width(input int max_len);
      return $clog2(max_len) + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/npu_cube_add_csa.sv
`default_nettype none
// ============================================================================
// Module  : npu_cube_add_csa
// Purpose : Combinational W-bit 3:2 compressor row. Reduces three addends to
//           a sum word and a carry word (carry already shifted left by one,
//           truncated to W bits).
// Ports   : i_x, i_y, i_z  - addends (W bits)
//           o_sum          - bitwise sum x^y^z
//           o_carry        - majority(x,y,z) << 1
// Rev     : 1.0  initial release
// ============================================================================
module npu_cube_add_csa #(
   parameter int W = 12
) (
   input  logic [W-1:0] i_x,
   input  logic [W-1:0] i_y,
   input  logic [W-1:0] i_z,
   output logic [W-1:0] o_sum,
   output logic [W-1:0] o_carry
);

   logic [W-1:0] w_maj;

   assign w_maj   = (i_x & i_y) | (i_x & i_z) | (i_y & i_z);
   assign o_sum   = i_x ^ i_y ^ i_z;
   // MSB of the majority is dropped: results are taken modulo 2^W.
   assign o_carry = {w_maj[W-2:0], 1'b0};

endmodule
`default_nettype wire

// File: rtl/npu_cube_add_csacc.sv
`default_nettype none
// ============================================================================
// Module  : npu_cube_add_csacc
// Purpose : Multi-lane carry-save accumulator. Each lane sums a packet of
//           1..MAX_LEN operands in redundant sum/carry form (one beat per
//           cycle), then resolves S+C in a single carry-propagate cycle and
//           holds the result until the consumer takes it.
// Ports   : clk, rst          - clock, synchronous active-high reset
//           in_valid/in_ready - operand beat handshake
//           in_data           - LANES x DATA_W operands
//           in_last           - final beat of packet
//           out_valid/out_ready - result handshake
//           out_data          - LANES x ACC_W results
//           out_cnt           - number of operands summed
//           out_trunc         - packet cut at MAX_LEN without in_last
// Rev     : 1.0  initial release
// ============================================================================
module npu_cube_add_csacc
   import npu_cube_add_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int LANES   = 4,
   parameter int MAX_LEN = 16,
   parameter int SIGNED  = 0,
   localparam int ACC_W  = acc_width(DATA_W, MAX_LEN),
   localparam int CNT_W  = cnt_width(MAX_LEN)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES*DATA_W-1:0] in_data,
   input  logic                    in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANES*ACC_W-1:0]  out_data,
   output logic [CNT_W-1:0]        out_cnt,
   output logic                    out_trunc
);

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic [CNT_W-1:0]         r_cnt;
   logic                     r_trunc;
   logic [LANES*ACC_W-1:0]   r_s;
   logic [LANES*ACC_W-1:0]   r_c;
   logic [LANES*ACC_W-1:0]   w_x;
   logic [LANES*ACC_W-1:0]   w_sum;
   logic [LANES*ACC_W-1:0]   w_carry;
   logic [LANES*ACC_W-1:0]   w_res;
   logic                     w_accept;
   logic [CNT_W-1:0]         w_cnt_nxt;
   logic                     w_at_limit;
   logic                     w_end;

   // ------------------------------------------------------------------
   // Per-lane operand extension, compressor row and resolve adder
   // ------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         logic w_ext;
         assign w_ext = (SIGNED != 0) ? in_data[gi*DATA_W + DATA_W - 1] : 1'b0;
         assign w_x[gi*ACC_W +: ACC_W] =
            {{(ACC_W-DATA_W){w_ext}}, in_data[gi*DATA_W +: DATA_W]};

         npu_cube_add_csa #(.W(ACC_W)) u_csa (
            .i_x     (r_s[gi*ACC_W +: ACC_W]),
            .i_y     (r_c[gi*ACC_W +: ACC_W]),
            .i_z     (w_x[gi*ACC_W +: ACC_W]),
            .o_sum   (w_sum[gi*ACC_W +: ACC_W]),
            .o_carry (w_carry[gi*ACC_W +: ACC_W])
         );

         assign w_res[gi*ACC_W +: ACC_W] = r_s[gi*ACC_W +: ACC_W] + r_c[gi*ACC_W +: ACC_W];
      end
   endgenerate

   // ------------------------------------------------------------------
   // Handshake and packet termination
   // ------------------------------------------------------------------
   assign in_ready  = !rst && ((r_state == IDLE) || (r_state == ACC));
   assign out_valid = (r_state == HOLD);
   assign w_accept  = in_valid && in_ready;

   // Count including the beat being accepted; a fresh packet restarts at 1
   // regardless of the count left over from the previous packet.
   assign w_cnt_nxt  = (r_state == IDLE) ? CNT_W'(1) : (r_cnt + CNT_W'(1));
   assign w_at_limit = (w_cnt_nxt == CNT_W'(MAX_LEN));
   assign w_end      = in_last || w_at_limit;

   // ------------------------------------------------------------------
   // FSM next state
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE, ACC: begin
            if (w_accept) begin
               w_state_nxt = w_end ? RESOLVE : ACC;
            end
         end
         RESOLVE: w_state_nxt = HOLD;
         HOLD: begin
            if (out_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // State, accumulators and output registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_s       <= '0;
         r_c       <= '0;
         r_cnt     <= '0;
         r_trunc   <= 1'b0;
         out_data  <= '0;
         out_cnt   <= '0;
         out_trunc <= 1'b0;
      end else begin
         r_state <= w_state_nxt;

         if (w_accept) begin
            if (r_state == IDLE) begin
               r_s <= w_x;
               r_c <= '0;
            end else begin
               r_s <= w_sum;
               r_c <= w_carry;
            end
            r_cnt   <= w_cnt_nxt;
            r_trunc <= w_at_limit && !in_last;
         end

         if (r_state == RESOLVE) begin
            out_data  <= w_res;
            out_cnt   <= r_cnt;
            out_trunc <= r_trunc;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_npu_cube_add_csacc.sv
`default_nettype none
// ============================================================================
// Module  : tb_npu_cube_add_csacc
// Purpose : Self-checking bench for npu_cube_add_csacc. An unsigned and a
//           signed instance share one stimulus stream; a reference model
//           pushes expected results for both into a scoreboard queue.
// Rev     : 1.0  initial release
// ============================================================================
module tb_npu_cube_add_csacc;

   localparam int DATA_W  = 8;
   localparam int LANES   = 4;
   localparam int MAX_LEN = 16;
   localparam int ACC_W   = 12;
   localparam int CNT_W   = 5;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic                    in_valid = 1'b0;
   logic                    in_last = 1'b0;
   logic                    out_ready = 1'b0;
   logic [LANES*DATA_W-1:0] in_data = '0;

   logic                    in_ready_u, in_ready_s;
   logic                    out_valid_u, out_valid_s;
   logic [LANES*ACC_W-1:0]  out_data_u, out_data_s;
   logic [CNT_W-1:0]        out_cnt_u, out_cnt_s;
   logic                    out_trunc_u, out_trunc_s;

   always #5 clk = ~clk;

   npu_cube_add_csacc #(.DATA_W(DATA_W), .LANES(LANES), .MAX_LEN(MAX_LEN), .SIGNED(0)) u_dut_u (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u), .in_data(in_data),
      .in_last(in_last), .out_valid(out_valid_u), .out_ready(out_ready), .out_data(out_data_u),
      .out_cnt(out_cnt_u), .out_trunc(out_trunc_u));

   npu_cube_add_csacc #(.DATA_W(DATA_W), .LANES(LANES), .MAX_LEN(MAX_LEN), .SIGNED(1)) u_dut_s (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
      .in_last(in_last), .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
      .out_cnt(out_cnt_s), .out_trunc(out_trunc_s));

   typedef struct {
      logic [LANES*ACC_W-1:0] u;
      logic [LANES*ACC_W-1:0] s;
      logic [CNT_W-1:0]       cnt;
      logic                   trunc;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   m_u[LANES];
   int   m_s[LANES];
   int   m_cnt = 0;

   function automatic void model_clear();
      m_cnt = 0;
      for (int l = 0; l < LANES; l++) begin
         m_u[l] = 0;
         m_s[l] = 0;
      end
   endfunction

   // Drive one beat (waits for in_ready) and advance the reference model.
   task automatic send_beat(input logic [LANES*DATA_W-1:0] d, input logic last);
      int   t = 0;
      exp_t e;
      logic [DATA_W-1:0] b;
      while (!in_ready_u && t < 50) begin
         @(posedge clk); #1; t++;
      end
      checks++;
      if (!in_ready_u || !in_ready_s) begin
         failures++;
         $display("FAIL send_ready: in_ready u=%0b s=%0b required 1", in_ready_u, in_ready_s);
         return;
      end
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      for (int l = 0; l < LANES; l++) begin
         b = d[l*DATA_W +: DATA_W];
         m_u[l] += int'(b);
         m_s[l] += int'($signed(b));
      end
      m_cnt++;
      if (last || m_cnt == MAX_LEN) begin
         for (int l = 0; l < LANES; l++) begin
            e.u[l*ACC_W +: ACC_W] = m_u[l][ACC_W-1:0];
            e.s[l*ACC_W +: ACC_W] = m_s[l][ACC_W-1:0];
         end
         e.cnt   = m_cnt[CNT_W-1:0];
         e.trunc = !last && (m_cnt == MAX_LEN);
         sb.push_back(e);
         model_clear();
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Wait for a result, compare against the scoreboard, optionally apply
   // back-pressure for 'hold' cycles, then complete the handshake.
   task automatic drain(input int hold);
      int   t = 0;
      exp_t e;
      while (!out_valid_u && t < 50) begin
         @(posedge clk); #1; t++;
      end
      checks++;
      if (!out_valid_u || !out_valid_s || sb.size() == 0) begin
         failures++;
         $display("FAIL drain_valid: out_valid u=%0b s=%0b queued=%0d required valid with entry",
                  out_valid_u, out_valid_s, sb.size());
         return;
      end
      e = sb.pop_front();
      checks++;
      if (out_data_u !== e.u) begin
         failures++;
         $display("FAIL data_unsigned: got %h required %h", out_data_u, e.u);
      end
      checks++;
      if (out_data_s !== e.s) begin
         failures++;
         $display("FAIL data_signed: got %h required %h", out_data_s, e.s);
      end
      checks++;
      if (out_cnt_u !== e.cnt || out_cnt_s !== e.cnt) begin
         failures++;
         $display("FAIL out_cnt: got u=%0d s=%0d required %0d", out_cnt_u, out_cnt_s, e.cnt);
      end
      checks++;
      if (out_trunc_u !== e.trunc || out_trunc_s !== e.trunc) begin
         failures++;
         $display("FAIL out_trunc: got u=%0b s=%0b required %0b", out_trunc_u, out_trunc_s, e.trunc);
      end
      for (int h = 0; h < hold; h++) begin
         out_ready = 1'b0;
         @(posedge clk); #1;
         checks++;
         if (out_data_u !== e.u || !out_valid_u || in_ready_u) begin
            failures++;
            $display("FAIL hold_stable: data=%h valid=%0b in_ready=%0b required data=%h valid=1 in_ready=0",
                     out_data_u, out_valid_u, in_ready_u, e.u);
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (out_valid_u || out_valid_s || !in_ready_u || !in_ready_s) begin
         failures++;
         $display("FAIL release_idle: out_valid=%0b in_ready=%0b required out_valid=0 in_ready=1",
                  out_valid_u, in_ready_u);
      end
   endtask

   task automatic check_latency(input string name);
      checks++;
      if (out_valid_u !== 1'b0 || in_ready_u !== 1'b0) begin
         failures++;
         $display("FAIL %s_resolve: out_valid=%0b in_ready=%0b required 0 0", name, out_valid_u, in_ready_u);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid_u !== 1'b1 || out_valid_s !== 1'b1) begin
         failures++;
         $display("FAIL %s_latency: out_valid u=%0b s=%0b required 1", name, out_valid_u, out_valid_s);
      end
   endtask

   task automatic check_zero(input string name);
      checks++;
      if (out_valid_u !== 1'b0 || out_data_u !== '0 || out_cnt_u !== '0 || out_trunc_u !== 1'b0 ||
          out_valid_s !== 1'b0 || out_data_s !== '0 || out_cnt_s !== '0 || in_ready_u !== 1'b0) begin
         failures++;
         $display("FAIL %s: valid=%0b data=%h cnt=%0d trunc=%0b in_ready=%0b required all 0",
                  name, out_valid_u, out_data_u, out_cnt_u, out_trunc_u, in_ready_u);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset_state");
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready_u !== 1'b1 || out_valid_u !== 1'b0) begin
         failures++;
         $display("FAIL reset_release: in_ready=%0b out_valid=%0b required 1 0", in_ready_u, out_valid_u);
      end
   endtask

   task automatic test_basic();
      send_beat({8'd3, 8'd2, 8'd1, 8'd255}, 1'b0);
      send_beat({8'd3, 8'd2, 8'd1, 8'd255}, 1'b0);
      send_beat({8'd3, 8'd2, 8'd1, 8'd255}, 1'b1);
      check_latency("basic");
      checks++;
      if (out_data_u[ACC_W-1:0] !== 12'd765 || out_cnt_u !== 5'd3) begin
         failures++;
         $display("FAIL basic_765: lane0=%0d cnt=%0d required 765 3", out_data_u[ACC_W-1:0], out_cnt_u);
      end
      drain(0);
   endtask

   task automatic test_single();
      send_beat({4{8'h5A}}, 1'b1);
      check_latency("single");
      checks++;
      if (out_data_u !== {4{12'h05A}} || out_cnt_u !== 5'd1) begin
         failures++;
         $display("FAIL single_5a: data=%h cnt=%0d required %h 1", out_data_u, out_cnt_u, {4{12'h05A}});
      end
      drain(0);
   endtask

   task automatic test_signed();
      send_beat({4{8'h80}}, 1'b0);
      send_beat({4{8'h80}}, 1'b0);
      send_beat({4{8'h01}}, 1'b1);
      @(posedge clk); #1;
      checks++;
      if (out_data_s !== {4{12'hF01}} || out_data_u !== {4{12'h101}}) begin
         failures++;
         $display("FAIL signed_m255: s=%h u=%h required %h %h", out_data_s, out_data_u,
                  {4{12'hF01}}, {4{12'h101}});
      end
      drain(0);
   endtask

   task automatic test_trunc();
      for (int i = 0; i < MAX_LEN; i++) send_beat({4{8'hFF}}, 1'b0);
      checks++;
      if (in_ready_u !== 1'b0) begin
         failures++;
         $display("FAIL trunc_stop: in_ready=%0b required 0", in_ready_u);
      end
      @(posedge clk); #1;
      checks++;
      if (out_data_u[ACC_W-1:0] !== 12'd4080 || out_cnt_u !== 5'd16 || out_trunc_u !== 1'b1) begin
         failures++;
         $display("FAIL trunc_4080: lane0=%0d cnt=%0d trunc=%0b required 4080 16 1",
                  out_data_u[ACC_W-1:0], out_cnt_u, out_trunc_u);
      end
      drain(0);
      send_beat({4{8'd9}}, 1'b1);
      drain(0);
   endtask

   task automatic test_backpressure();
      send_beat({8'd40, 8'd30, 8'd20, 8'd10}, 1'b0);
      send_beat({8'd4, 8'd3, 8'd2, 8'd1}, 1'b1);
      drain(5);
   endtask

   task automatic test_reset_mid();
      send_beat({4{8'd100}}, 1'b0);
      send_beat({4{8'd100}}, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      check_zero("reset_mid_acc");
      model_clear();
      rst = 1'b0;
      send_beat({4{8'd7}}, 1'b1);
      drain(0);
      // Reset while a result is pending in HOLD discards it.
      send_beat({4{8'd50}}, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check_zero("reset_hold");
      void'(sb.pop_front());
      rst = 1'b0;
      send_beat({4{8'd7}}, 1'b1);
      drain(0);
   endtask

   task automatic test_back_to_back();
      for (int p = 0; p < 6; p++) begin
         int len = int'($urandom_range(1, 20));
         for (int b = 0; b < len; b++) begin
            send_beat($urandom, (b == len - 1));
            if (sb.size() > 0) drain(int'($urandom_range(0, 2)));
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_clear();
      test_reset();
      test_basic();
      test_single();
      test_signed();
      test_trunc();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_empty: %0d entries left required 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
